// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller: funct3 encodings,
// controller states and access-size decode / load-extension helpers.
`ifndef DATA_MEM_ADDR_WIDTH
`define DATA_MEM_ADDR_WIDTH 32
`endif

package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      ACC1 = 3'd2,
      RESP = 3'd3,
      ERR  = 3'd4
   } lsu_state_e;

   typedef struct packed {
      logic       legal;
      logic [2:0] size;
   } size_dec_t;

   // Unsigned variants only exist for loads; stores of 1xx are illegal.
   function automatic size_dec_t size_decode(input logic we, input logic [2:0] f3);
      size_dec_t d;
      d.legal = 1'b1;
      d.size  = 3'd4;
      case (f3)
         F3_B:  d.size = 3'd1;
         F3_H:  d.size = 3'd2;
         F3_W:  d.size = 3'd4;
         F3_BU: begin d.size = 3'd1; d.legal = ~we; end
         F3_HU: begin d.size = 3'd2; d.legal = ~we; end
         default: begin d.size = 3'd4; d.legal = 1'b0; end
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
      logic [31:0] r;
      case (f3)
         F3_B:    r = {{24{raw[7]}}, raw[7:0]};
         F3_H:    r = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   r = {24'd0, raw[7:0]};
         F3_HU:   r = {16'd0, raw[15:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering for one part of an access: byte strobe, shifted
// store data, masked read bytes and the byte shift that right-justifies a load.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  size,
   input  logic        part,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  strb,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_masked,
   output logic [2:0]  rshift
);

   logic [3:0]  sh;
   logic [7:0]  ones;
   logic [7:0]  smask;
   logic [63:0] wwin;

   // Place the access in an 8-byte window (offset 0 = MSB) and pick this part's word.
   always_comb begin
      sh = 4'd8 - {2'b00, off} - {1'b0, size};
      case (size)
         3'd1:    ones = 8'h01;
         3'd2:    ones = 8'h03;
         default: ones = 8'h0F;
      endcase
      smask = ones << sh;
      wwin  = {32'd0, wdata} << {sh, 3'b000};
      if (part) begin
         strb       = smask[3:0];
         wdata_lane = wwin[31:0];
      end else begin
         strb       = smask[7:4];
         wdata_lane = wwin[63:32];
      end
      rdata_masked = rdata & {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      rshift       = sh[2:0];
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: drives a big-endian word memory, splitting
// word-boundary-crossing accesses into two transactions and merging the result.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_ADDR_W       = `DATA_MEM_ADDR_WIDTH,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [MEM_ADDR_W-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  Mem_r,
   output logic                  Mem_w,
   output logic [MEM_ADDR_W-1:0] Mem_Addr,
   output logic [31:0]           Mem_W_Data,
   output logic [3:0]            Mem_W_Strb,
   input  logic [31:0]           Mem_R_Data
);

   lsu_state_e            state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            f3_q, f3_d;
   logic [2:0]            size_q, size_d;
   logic                  split_q, split_d;
   logic [MEM_ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [63:0]           rwin_q, rwin_d;
   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_err_q, resp_err_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;
   logic                  mem_r_q, mem_r_d;
   logic                  mem_w_q, mem_w_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_strb_q, mem_strb_d;

   size_dec_t             req_dec;
   logic                  req_split;
   logic [1:0]            st_off;
   logic [2:0]            st_size;
   logic                  st_part;
   logic [31:0]           st_wdata;
   logic [3:0]            st_strb;
   logic [31:0]           st_wlane;
   logic [31:0]           st_rmask;
   logic [2:0]            st_rshift;
   logic [3:0]            ld_strb;
   logic [31:0]           ld_wlane;
   logic [31:0]           ld_rmask;
   logic [2:0]            ld_rshift;
   logic [63:0]           rwin_next;
   logic [63:0]           rwin_shr;
   logic [MEM_ADDR_W-3:0] word_inc;
   logic                  unused_ok;

   // Request decode and operand selection for the store-side lane aligner.
   always_comb begin
      req_dec   = size_decode(req_we, req_funct3);
      req_split = ({1'b0, req_addr[1:0]} + req_dec.size) > 3'd4;
      if (state_q == IDLE) begin
         st_off   = req_addr[1:0];
         st_size  = req_dec.size;
         st_part  = 1'b0;
         st_wdata = req_wdata;
      end else begin
         st_off   = addr_q[1:0];
         st_size  = size_q;
         st_part  = 1'b1;
         st_wdata = wdata_q;
      end
   end

   lsu_lane_align u_store_align (
      .off          (st_off),
      .size         (st_size),
      .part         (st_part),
      .wdata        (st_wdata),
      .rdata        (32'd0),
      .strb         (st_strb),
      .wdata_lane   (st_wlane),
      .rdata_masked (st_rmask),
      .rshift       (st_rshift)
   );

   lsu_lane_align u_load_align (
      .off          (addr_q[1:0]),
      .size         (size_q),
      .part         (state_q == ACC1),
      .wdata        (32'd0),
      .rdata        (Mem_R_Data),
      .strb         (ld_strb),
      .wdata_lane   (ld_wlane),
      .rdata_masked (ld_rmask),
      .rshift       (ld_rshift)
   );

   assign unused_ok = ^{st_rmask, st_rshift, ld_strb, ld_wlane};

   // Merge this part's read bytes and right-justify the complete value.
   always_comb begin
      if (state_q == ACC1) begin
         rwin_next = rwin_q | {32'd0, ld_rmask};
      end else begin
         rwin_next = rwin_q | {ld_rmask, 32'd0};
      end
      rwin_shr = rwin_next >> {ld_rshift, 3'b000};
      word_inc = addr_q[MEM_ADDR_W-1:2] + (MEM_ADDR_W-2)'(1);
   end

   // Next-state and registered-output logic; memory signals default to idle.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      f3_d         = f3_q;
      size_d       = size_q;
      split_d      = split_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rwin_d       = rwin_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      mem_r_d      = 1'b0;
      mem_w_d      = 1'b0;
      mem_addr_d   = {MEM_ADDR_W{1'b0}};
      mem_wdata_d  = 32'd0;
      mem_strb_d   = 4'd0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               size_d  = req_dec.size;
               split_d = req_split;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rwin_d  = 64'd0;
               if (!req_dec.legal || (req_split && !ALLOW_MISALIGNED)) begin
                  state_d      = ERR;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'd0;
               end else begin
                  state_d     = ACC0;
                  mem_r_d     = ~req_we;
                  mem_w_d     = req_we;
                  mem_addr_d  = {req_addr[MEM_ADDR_W-1:2], 2'b00};
                  mem_strb_d  = req_we ? st_strb : 4'd0;
                  mem_wdata_d = req_we ? st_wlane : 32'd0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACC0: begin
            rwin_d = rwin_next;
            if (split_q) begin
               state_d     = ACC1;
               mem_r_d     = ~we_q;
               mem_w_d     = we_q;
               mem_addr_d  = {word_inc, 2'b00};
               mem_strb_d  = we_q ? st_strb : 4'd0;
               mem_wdata_d = we_q ? st_wlane : 32'd0;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = we_q ? 32'd0 : load_extend(f3_q, rwin_shr[31:0]);
            end
         end
         ACC1: begin
            rwin_d       = rwin_next;
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = we_q ? 32'd0 : load_extend(f3_q, rwin_shr[31:0]);
         end
         RESP, ERR: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = 32'd0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'd0;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'd0;
         size_q       <= 3'd0;
         split_q      <= 1'b0;
         addr_q       <= {MEM_ADDR_W{1'b0}};
         wdata_q      <= 32'd0;
         rwin_q       <= 64'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
         mem_r_q      <= 1'b0;
         mem_w_q      <= 1'b0;
         mem_addr_q   <= {MEM_ADDR_W{1'b0}};
         mem_wdata_q  <= 32'd0;
         mem_strb_q   <= 4'd0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         size_q       <= size_d;
         split_q      <= split_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rwin_q       <= rwin_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_r_q      <= mem_r_d;
         mem_w_q      <= mem_w_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_strb_q   <= mem_strb_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign Mem_r      = mem_r_q;
   assign Mem_w      = mem_w_q;
   assign Mem_Addr   = mem_addr_q;
   assign Mem_W_Data = mem_wdata_q;
   assign Mem_W_Strb = mem_strb_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl against a big-endian word memory model.
module tb_lsu_ctrl;
   import lsu_pkg::*;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        Mem_r;
   logic        Mem_w;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_W_Data;
   logic [3:0]  Mem_W_Strb;
   logic [31:0] Mem_R_Data;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63] = '{default: 32'd0};
   logic        log_we   [0:127];
   logic [31:0] log_addr [0:127];
   logic [31:0] log_data [0:127];
   logic [3:0]  log_strb [0:127];
   int          log_total = 0;
   int          rw_both   = 0;

   lsu_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .Mem_r      (Mem_r),
      .Mem_w      (Mem_w),
      .Mem_Addr   (Mem_Addr),
      .Mem_W_Data (Mem_W_Data),
      .Mem_W_Strb (Mem_W_Strb),
      .Mem_R_Data (Mem_R_Data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign Mem_R_Data = mem[Mem_Addr[7:2]];

   // Memory model: lane k holds byte offset k, enabled by strobe bit 3-k.
   always @(posedge clk) begin
      if (Mem_r && Mem_w) rw_both++;
      if ((Mem_r || Mem_w) && log_total < 128) begin
         log_we[log_total]   = Mem_w;
         log_addr[log_total] = Mem_Addr;
         log_data[log_total] = Mem_W_Data;
         log_strb[log_total] = Mem_W_Strb;
         log_total++;
      end
      if (Mem_w) begin
         for (int k = 0; k < 4; k++) begin
            if (Mem_W_Strb[3-k]) mem[Mem_Addr[7:2]][31-8*k -: 8] = Mem_W_Data[31-8*k -: 8];
         end
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      rd = resp_rdata;
      err = resp_err;
      if (resp_valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL resp_timeout addr=%h got resp_valid=%b req 1", addr, resp_valid);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp got v=%b e=%b exp 0 0", resp_valid, resp_err); end
      checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
      checks++; if (Mem_r !== 1'b0 || Mem_w !== 1'b0) begin errors++; $display("FAIL rst_mem_rw got r=%b w=%b exp 0 0", Mem_r, Mem_w); end
      checks++; if (Mem_Addr !== 32'd0 || Mem_W_Data !== 32'd0 || Mem_W_Strb !== 4'd0) begin errors++; $display("FAIL rst_mem_bus got a=%h d=%h s=%b exp 0", Mem_Addr, Mem_W_Data, Mem_W_Strb); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic err; int lat; int b;
      b = log_total;
      do_req(1'b1, F3_W, 32'h10, 32'h11223344, rd, err, lat);
      checks++; if (log_total - b !== 1) begin errors++; $display("FAIL sw_count got %0d exp 1", log_total - b); end
      checks++; if (log_we[b] !== 1'b1 || log_addr[b] !== 32'h10) begin errors++; $display("FAIL sw_cmd got we=%b a=%h exp 1 10", log_we[b], log_addr[b]); end
      checks++; if (log_strb[b] !== 4'b1111 || log_data[b] !== 32'h11223344) begin errors++; $display("FAIL sw_data got s=%b d=%h exp 1111 11223344", log_strb[b], log_data[b]); end
      checks++; if (rd !== 32'd0 || err !== 1'b0 || lat !== 2) begin errors++; $display("FAIL sw_resp got rd=%h err=%b lat=%0d exp 0 0 2", rd, err, lat); end
      b = log_total;
      do_req(1'b0, F3_W, 32'h10, 32'h0, rd, err, lat);
      checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lw_data got %h exp 11223344", rd); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
      checks++; if (log_total - b !== 1 || log_we[b] !== 1'b0 || log_addr[b] !== 32'h10) begin errors++; $display("FAIL lw_cmd got n=%0d we=%b a=%h exp 1 0 10", log_total - b, log_we[b], log_addr[b]); end
   endtask

   task automatic test_byte();
      logic [31:0] rd; logic err; int lat; int b;
      b = log_total;
      do_req(1'b1, F3_B, 32'h13, 32'h000000AB, rd, err, lat);
      checks++; if (log_strb[b] !== 4'b0001 || log_data[b][7:0] !== 8'hAB || log_addr[b] !== 32'h10) begin errors++; $display("FAIL sb_cmd got s=%b d=%h a=%h exp 0001 ..AB 10", log_strb[b], log_data[b], log_addr[b]); end
      do_req(1'b0, F3_B, 32'h13, 32'h0, rd, err, lat);
      checks++; if (rd !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_data got %h exp FFFFFFAB", rd); end
      do_req(1'b0, F3_BU, 32'h13, 32'h0, rd, err, lat);
      checks++; if (rd !== 32'h000000AB) begin errors++; $display("FAIL lbu_data got %h exp 000000AB", rd); end
   endtask

   task automatic test_half();
      logic [31:0] rd; logic err; int lat; int b;
      b = log_total;
      do_req(1'b1, F3_H, 32'h11, 32'h0000BEEF, rd, err, lat);
      checks++; if (log_strb[b] !== 4'b0110 || log_data[b][23:8] !== 16'hBEEF) begin errors++; $display("FAIL sh_cmd got s=%b d=%h exp 0110 ..BEEF..", log_strb[b], log_data[b]); end
      do_req(1'b0, F3_H, 32'h11, 32'h0, rd, err, lat);
      checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_data got %h exp FFFFBEEF", rd); end
      do_req(1'b0, F3_HU, 32'h11, 32'h0, rd, err, lat);
      checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_data got %h exp 0000BEEF", rd); end
   endtask

   task automatic test_split();
      logic [31:0] rd; logic err; int lat; int b;
      do_req(1'b1, F3_W, 32'h0C, 32'hAABBCCDD, rd, err, lat);
      do_req(1'b1, F3_W, 32'h10, 32'h11223344, rd, err, lat);
      b = log_total;
      do_req(1'b0, F3_W, 32'h0E, 32'h0, rd, err, lat);
      checks++; if (log_total - b !== 2) begin errors++; $display("FAIL lw_split_count got %0d exp 2", log_total - b); end
      checks++; if (log_we[b] !== 1'b0 || log_addr[b] !== 32'h0C || log_we[b+1] !== 1'b0 || log_addr[b+1] !== 32'h10) begin errors++; $display("FAIL lw_split_addr got %h %h exp 0C 10", log_addr[b], log_addr[b+1]); end
      checks++; if (rd !== 32'hCCDD1122 || lat !== 3) begin errors++; $display("FAIL lw_split_data got %h lat %0d exp CCDD1122 3", rd, lat); end
      b = log_total;
      do_req(1'b1, F3_W, 32'h0E, 32'h55667788, rd, err, lat);
      checks++; if (log_addr[b] !== 32'h0C || log_strb[b] !== 4'b0011 || log_data[b] !== 32'h00005566) begin errors++; $display("FAIL sw_split_p0 got a=%h s=%b d=%h exp 0C 0011 00005566", log_addr[b], log_strb[b], log_data[b]); end
      checks++; if (log_addr[b+1] !== 32'h10 || log_strb[b+1] !== 4'b1100 || log_data[b+1] !== 32'h77880000) begin errors++; $display("FAIL sw_split_p1 got a=%h s=%b d=%h exp 10 1100 77880000", log_addr[b+1], log_strb[b+1], log_data[b+1]); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL sw_split_latency got %0d exp 3", lat); end
      do_req(1'b0, F3_W, 32'h0C, 32'h0, rd, err, lat);
      checks++; if (rd !== 32'hAABB5566) begin errors++; $display("FAIL sw_split_word0 got %h exp AABB5566", rd); end
      do_req(1'b0, F3_W, 32'h10, 32'h0, rd, err, lat);
      checks++; if (rd !== 32'h77883344) begin errors++; $display("FAIL sw_split_word1 got %h exp 77883344", rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd; logic err; int lat; int b;
      do_req(1'b1, F3_W, 32'hFFFFFFFC, 32'h010203F4, rd, err, lat);
      do_req(1'b1, F3_W, 32'h00000000, 32'h05060708, rd, err, lat);
      b = log_total;
      do_req(1'b0, F3_H, 32'hFFFFFFFF, 32'h0, rd, err, lat);
      checks++; if (log_addr[b] !== 32'hFFFFFFFC || log_addr[b+1] !== 32'h00000000) begin errors++; $display("FAIL wrap_addr got %h %h exp FFFFFFFC 00000000", log_addr[b], log_addr[b+1]); end
      checks++; if (rd !== 32'hFFFFF405 || lat !== 3) begin errors++; $display("FAIL wrap_data got %h lat %0d exp FFFFF405 3", rd, lat); end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < 3; i++) begin
         checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b exp 1", i, resp_valid); end
         checks++; if (resp_rdata !== 32'h77883344) begin errors++; $display("FAIL bp_rdata cyc %0d got %h exp 77883344", i, resp_rdata); end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc %0d got %b exp 0", i, req_ready); end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
   endtask

   task automatic test_error();
      logic [31:0] rd; logic err; int lat; int b;
      b = log_total;
      do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat);
      checks++; if (err !== 1'b1 || lat !== 1 || rd !== 32'd0) begin errors++; $display("FAIL ld_f3_011 got err=%b lat=%0d rd=%h exp 1 1 0", err, lat, rd); end
      checks++; if (log_total - b !== 0) begin errors++; $display("FAIL ld_f3_011_mem got %0d accesses exp 0", log_total - b); end
      do_req(1'b1, F3_BU, 32'h10, 32'hFFFFFFFF, rd, err, lat);
      checks++; if (err !== 1'b1 || lat !== 1 || log_total - b !== 0) begin errors++; $display("FAIL st_f3_100 got err=%b lat=%0d n=%0d exp 1 1 0", err, lat, log_total - b); end
      do_req(1'b0, F3_W, 32'h10, 32'h0, rd, err, lat);
      checks++; if (err !== 1'b0 || rd !== 32'h77883344) begin errors++; $display("FAIL post_err_lw got err=%b rd=%h exp 0 77883344", err, rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic err; int lat;
      do_req(1'b1, F3_W, 32'h0C, 32'h0, rd, err, lat);
      do_req(1'b1, F3_W, 32'h10, 32'h0, rd, err, lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h0E; req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (Mem_w !== 1'b1) begin errors++; $display("FAIL mid_acc0 got Mem_w=%b exp 1", Mem_w); end
      #1 rst = 1'b1;
      #1;
      checks++; if (Mem_w !== 1'b0 || Mem_r !== 1'b0) begin errors++; $display("FAIL mid_async_drop got r=%b w=%b exp 0 0", Mem_r, Mem_w); end
      repeat (2) begin
         @(negedge clk);
         checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_valid got %b exp 0", resp_valid); end
      end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready got %b exp 1", req_ready); end
      do_req(1'b0, F3_W, 32'h0C, 32'h0, rd, err, lat);
      checks++; if (rd !== 32'h0 || err !== 1'b0 || lat !== 2) begin errors++; $display("FAIL mid_next_lw got rd=%h err=%b lat=%0d exp 0 0 2", rd, err, lat); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_split();
      test_wrap();
      test_backpressure();
      test_error();
      test_reset_mid();
      checks++; if (rw_both !== 0) begin errors++; $display("FAIL rw_exclusive got %0d overlaps exp 0", rw_both); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
